branch_predictor_gshare: RTL

//   Parametrised successor to the bimodal 2-bit predictor: a table of 2-bit saturating

---
 rtl/branch_predictor_gshare.sv | 105 ++++++++++
 1 files changed

// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_gshare
// Description : 2-bit saturating-counter branch predictor, bimodal or gshare
//               indexed, with a speculative GHR and commit-time accuracy counts.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_gshare #(
  parameter int         XLEN          = 32,
  parameter int         BP_SIZE_WIDTH = 6,
  parameter int         HIST_LEN      = 6,
  parameter int         IDX_LSB       = 1,
  parameter int         MODE          = 1,
  parameter logic [1:0] CTR_INIT      = 2'b01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fet_valid,
  input  logic [XLEN-1:0]     fet_pc,
  output logic                bp_pred,
  output logic [HIST_LEN-1:0] bp_ghr,
  input  logic                rob_bp_enable,
  input  logic [XLEN-1:0]     rob_bp_inst_addr,
  input  logic [HIST_LEN-1:0] rob_bp_ghr,
  input  logic                rob_bp_jump,
  input  logic                rob_bp_correct,
  output logic [XLEN-1:0]     bp_correct_cnt,
  output logic [XLEN-1:0]     bp_total_cnt
);

  localparam int ENTRIES = 1 << BP_SIZE_WIDTH;

  logic [1:0]               table_q [ENTRIES];
  logic [1:0]               table_d [ENTRIES];
  logic [HIST_LEN-1:0]      ghr_q, ghr_d;
  logic [XLEN-1:0]          total_q, total_d;
  logic [XLEN-1:0]          correct_q, correct_d;

  logic [BP_SIZE_WIDTH-1:0] fhist, uhist;
  logic [BP_SIZE_WIDTH-1:0] fidx, uidx;
  logic [1:0]               ctr;

  // Only the index window of each PC is consumed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fet_pc, rob_bp_inst_addr};

  always_comb begin
    fhist = '0;
    uhist = '0;
    if (MODE != 0) begin
      fhist[HIST_LEN-1:0] = ghr_q;
      uhist[HIST_LEN-1:0] = rob_bp_ghr;
    end
    fidx = fet_pc[IDX_LSB +: BP_SIZE_WIDTH] ^ fhist;
    uidx = rob_bp_inst_addr[IDX_LSB +: BP_SIZE_WIDTH] ^ uhist;
  end

  // Reads the registered table, so a same-cycle update is not yet visible.
  assign bp_pred        = table_q[fidx][1];
  assign bp_ghr         = ghr_q;
  assign bp_correct_cnt = correct_q;
  assign bp_total_cnt   = total_q;

  always_comb begin
    table_d   = table_q;
    ctr       = table_q[uidx];
    total_d   = total_q;
    correct_d = correct_q;
    if (rob_bp_enable) begin
      if (rob_bp_jump) begin
        if (ctr != 2'b11) table_d[uidx] = ctr + 2'b01;
      end else begin
        if (ctr != 2'b00) table_d[uidx] = ctr - 2'b01;
      end
      if (total_q != '1) total_d = total_q + XLEN'(1);
      if (rob_bp_correct && (correct_q != '1)) correct_d = correct_q + XLEN'(1);
    end
  end

  // Mispredict repair takes priority: the fetch stream is being flushed.
  always_comb begin
    ghr_d = ghr_q;
    if (rob_bp_enable && !rob_bp_correct) begin
      ghr_d = HIST_LEN'(rob_bp_ghr << 1) | HIST_LEN'(rob_bp_jump);
    end else if (fet_valid) begin
      ghr_d = HIST_LEN'(ghr_q << 1) | HIST_LEN'(bp_pred);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
      ghr_q     <= '0;
      total_q   <= '0;
      correct_q <= '0;
    end else begin
      table_q   <= table_d;
      ghr_q     <= ghr_d;
      total_q   <= total_d;
      correct_q <= correct_d;
    end
  end

endmodule
`default_nettype wire
